spi_cmd_sequencer: RTL

- Upstream command stage for the SPI engine (spi_interface).
- Buffers pre-formatted SPI transactions in a command FIFO and issues them one at a time using the engine's request/busy handshake.
- Captures and masks read data, and queues it in a response FIFO for the register/host side.
- Lets device-configuration logic queue whole init sequences without tracking engine timing.

---
 rtl/spi_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_sequencer.sv
// Command sequencer in front of the SPI engine: queues pre-formatted transactions,
// issues them one at a time over the request/busy handshake and queues masked read data.
module spi_cmd_sequencer #(
    parameter int DEPTH_LOG2     = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cmd_wr_en,
    input  logic [31:0]           cmd_data,
    input  logic [5:0]            cmd_write_bits,
    input  logic [5:0]            cmd_read_bits,
    output logic                  cmd_full,
    output logic [DEPTH_LOG2:0]   cmd_count,
    input  logic                  rsp_rd_en,
    output logic [31:0]           rsp_data,
    output logic                  rsp_empty,
    output logic [DEPTH_LOG2:0]   rsp_count,
    output logic [31:0]           spi_data_out,
    output logic [5:0]            spi_write_bits,
    output logic [5:0]            spi_read_bits,
    output logic                  spi_request,
    input  logic                  spi_busy,
    input  logic [31:0]           spi_data_in,
    output logic                  idle,
    output logic                  overflow_err,
    output logic                  cmd_err,
    output logic                  timeout_err,
    input  logic                  clear_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;
    localparam int GW    = $clog2(GAP_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    // Command FIFO: entry = {data[31:0], write_bits[5:0], read_bits[5:0]}
    logic [43:0]   cmd_mem_q [DEPTH];
    logic [PW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;
    logic          cmd_push, cmd_pop, cmd_empty;

    logic [31:0]   rsp_mem_q [DEPTH];
    logic [PW-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic          rsp_push_req, rsp_push, rsp_pop, rsp_full;

    logic [31:0]   spi_data_q, spi_data_d;
    logic [5:0]    spi_wb_q, spi_wb_d, spi_rb_q, spi_rb_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;

    logic          ovf_q, ovf_d, cerr_q, cerr_d, terr_q, terr_d;
    logic          set_cmd_err, set_timeout;

    logic [43:0]   head;
    logic [31:0]   head_data;
    logic [5:0]    head_wb, head_rb;
    logic [6:0]    bits_sum;
    logic          head_valid;
    logic [31:0]   rd_mask, rsp_wdata;

    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_full  = (cmd_cnt_q == FULL_CNT);
    assign cmd_push  = cmd_wr_en && !cmd_full;

    assign rsp_empty = (rsp_cnt_q == '0);
    assign rsp_full  = (rsp_cnt_q == FULL_CNT);
    assign rsp_pop   = rsp_rd_en && !rsp_empty;
    // At full a push is only accepted alongside a pop; the FSM never needs more.
    assign rsp_push  = rsp_push_req && (!rsp_full || rsp_pop);

    assign head       = cmd_mem_q[cmd_rp_q];
    assign head_data  = head[43:12];
    assign head_wb    = head[11:6];
    assign head_rb    = head[5:0];
    assign bits_sum   = {1'b0, head_wb} + {1'b0, head_rb};
    assign head_valid = (bits_sum != 7'd0) && (bits_sum <= 7'd32);

    assign rd_mask   = (spi_rb_q >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << spi_rb_q) - 32'd1);
    assign rsp_wdata = spi_data_in & rd_mask;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wp_q] <= {cmd_data, cmd_write_bits, cmd_read_bits};
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem_q[rsp_wp_q] <= rsp_wdata;
        end
    end

    always_comb begin
        cmd_wp_d  = cmd_wp_q;
        cmd_rp_d  = cmd_rp_q;
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_push) cmd_wp_d = cmd_wp_q + PW'(1);
        if (cmd_pop)  cmd_rp_d = cmd_rp_q + PW'(1);
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CW'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CW'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
    end

    always_comb begin
        rsp_wp_d  = rsp_wp_q;
        rsp_rp_d  = rsp_rp_q;
        rsp_cnt_d = rsp_cnt_q;
        if (rsp_push) rsp_wp_d = rsp_wp_q + PW'(1);
        if (rsp_pop)  rsp_rp_d = rsp_rp_q + PW'(1);
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
            2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cmd_pop      = 1'b0;
        rsp_push_req = 1'b0;
        set_cmd_err  = 1'b0;
        set_timeout  = 1'b0;
        spi_data_d   = spi_data_q;
        spi_wb_d     = spi_wb_q;
        spi_rb_d     = spi_rb_q;
        gap_d        = gap_q;
        to_d         = to_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !cmd_empty && !spi_busy) begin
                    if (!head_valid) begin
                        cmd_pop     = 1'b1;
                        set_cmd_err = 1'b1;
                    end else if (!((head_rb != 6'd0) && rsp_full)) begin
                        cmd_pop    = 1'b1;
                        spi_data_d = head_data;
                        spi_wb_d   = head_wb;
                        spi_rb_d   = head_rb;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (spi_busy) begin
                    to_d    = to_q + TW'(1);
                    state_d = S_WAIT_DONE;
                end else if (to_q == TO_LAST) begin
                    set_timeout = 1'b1;
                    gap_d       = GAP_LOAD;
                    state_d     = S_GAP;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                // Completion takes precedence over a timeout landing in the same cycle.
                if (!spi_busy) begin
                    rsp_push_req = (spi_rb_q != 6'd0);
                    gap_d        = GAP_LOAD;
                    state_d      = S_GAP;
                end else if (to_q == TO_LAST) begin
                    set_timeout = 1'b1;
                    gap_d       = GAP_LOAD;
                    state_d     = S_GAP;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovf_d  = clear_err ? 1'b0 : (ovf_q  || (cmd_wr_en && cmd_full));
        cerr_d = clear_err ? 1'b0 : (cerr_q || set_cmd_err);
        terr_d = clear_err ? 1'b0 : (terr_q || set_timeout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_wp_q   <= '0;
            cmd_rp_q   <= '0;
            cmd_cnt_q  <= '0;
            rsp_wp_q   <= '0;
            rsp_rp_q   <= '0;
            rsp_cnt_q  <= '0;
            spi_data_q <= '0;
            spi_wb_q   <= '0;
            spi_rb_q   <= '0;
            gap_q      <= '0;
            to_q       <= '0;
            ovf_q      <= 1'b0;
            cerr_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_wp_q   <= cmd_wp_d;
            cmd_rp_q   <= cmd_rp_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rsp_wp_q   <= rsp_wp_d;
            rsp_rp_q   <= rsp_rp_d;
            rsp_cnt_q  <= rsp_cnt_d;
            spi_data_q <= spi_data_d;
            spi_wb_q   <= spi_wb_d;
            spi_rb_q   <= spi_rb_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            ovf_q      <= ovf_d;
            cerr_q     <= cerr_d;
            terr_q     <= terr_d;
        end
    end

    assign cmd_count      = cmd_cnt_q;
    assign rsp_count      = rsp_cnt_q;
    assign rsp_data       = rsp_empty ? 32'd0 : rsp_mem_q[rsp_rp_q];
    assign spi_data_out   = spi_data_q;
    assign spi_write_bits = spi_wb_q;
    assign spi_read_bits  = spi_rb_q;
    assign spi_request    = (state_q == S_ISSUE);
    assign idle           = (state_q == S_IDLE) && cmd_empty;
    assign overflow_err   = ovf_q;
    assign cmd_err        = cerr_q;
    assign timeout_err    = terr_q;

endmodule
